// File: rtl/edp_fm_ram.sv
// EDP fast-memory (AC) store: 128 x 36-bit words plus one odd-parity bit per 6-bit slice.
// After reset a scrub pass clears every word. Optional macro EDP_FM_PAR_INJECT_EN adds parity-fault injection on writes.
module edp_fm_ram #(
   parameter int NBLK = 8,
   parameter int NAC  = 16,
   parameter int W    = 36
) (
   input  logic                          clk_edp_h,
   input  logic                          reset_l,
   input  logic [$clog2(NAC)-1:0]        apr_fm_adr_h,
   input  logic [$clog2(NBLK)-1:0]       apr_fm_block_h,
   input  logic                          con_fm_write_l,
   input  logic [W-1:0]                  ar_h,
   input  logic                          con_fm_err_clr_h,
   input  logic                          diag_read_func_h,
`ifdef EDP_FM_PAR_INJECT_EN
   input  logic [W/6-1:0]                diag_fm_par_inv_h,
`endif
   output logic [W-1:0]                  fm_h,
   output logic [W/6-1:0]                fm_par_h,
   output logic [W/6-1:0]                edp_fm_parity_h,
   output logic                          fm_parity_err_h,
   output logic [$clog2(NBLK*NAC)-1:0]   fm_err_adr_h,
   output logic                          fm_init_busy_h,
   output logic [W-1:0]                  ebus_d_e_h,
   output logic                          ebus_en_h
);

   localparam int AW   = $clog2(NBLK * NAC);
   localparam int NSL  = W / 6;
   localparam int EPAD = W - 2 - AW - NSL;

   typedef enum logic {ST_SCRUB, ST_RUN} state_t;

   function automatic logic [NSL-1:0] slice_par(input logic [W-1:0] d);
      logic [NSL-1:0] p;
      for (int k = 0; k < NSL; k++) p[k] = ~^d[6*k +: 6];
      return p;
   endfunction

   // A slice is good when its six data bits plus its parity bit hold an odd count.
   function automatic logic par_bad(input logic [W-1:0] d, input logic [NSL-1:0] p);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < NSL; k++) bad = bad | ~(^{d[6*k +: 6], p[k]});
      return bad;
   endfunction

   logic [W-1:0]   r_mem [0:NBLK*NAC-1];
   logic [NSL-1:0] r_par [0:NBLK*NAC-1];

   state_t         r_state, w_state_nxt;
   logic [AW-1:0]  r_ptr;
   logic [W-1:0]   r_fm;
   logic [NSL-1:0] r_fm_par;
   logic           r_err;
   logic [AW-1:0]  r_err_adr;
   logic           r_ebus_en;
   logic [W-1:0]   r_ebus_d;

   logic [AW-1:0]  w_adr;
   logic [NSL-1:0] w_ar_par;
   logic [NSL-1:0] w_wr_par;
   logic           w_we;
   logic [AW-1:0]  w_wadr;
   logic [W-1:0]   w_wdata;
   logic [NSL-1:0] w_wpar;
   logic           w_busy;
   logic           w_rd_err;

   assign w_adr    = {apr_fm_block_h, apr_fm_adr_h};
   assign w_ar_par = slice_par(ar_h);
`ifdef EDP_FM_PAR_INJECT_EN
   assign w_wr_par = w_ar_par ^ diag_fm_par_inv_h;
`else
   assign w_wr_par = w_ar_par;
`endif
   assign w_busy   = (r_state == ST_SCRUB);
   assign w_rd_err = (r_state == ST_RUN) && con_fm_write_l && par_bad(r_mem[w_adr], r_par[w_adr]);

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_wadr      = w_adr;
      w_wdata     = ar_h;
      w_wpar      = w_wr_par;
      case (r_state)
         ST_SCRUB: begin
            w_we    = 1'b1;
            w_wadr  = r_ptr;
            w_wdata = '0;
            w_wpar  = '1;
            if (r_ptr == '1) w_state_nxt = ST_RUN;
         end
         ST_RUN:  w_we = ~con_fm_write_l;
         default: w_state_nxt = ST_SCRUB;
      endcase
   end

   always_ff @(posedge clk_edp_h) begin
      if (reset_l && w_we) begin
         r_mem[w_wadr] <= w_wdata;
         r_par[w_wadr] <= w_wpar;
      end
   end

   always_ff @(posedge clk_edp_h) begin
      if (!reset_l) begin
         r_state   <= ST_SCRUB;
         r_ptr     <= '0;
         r_fm      <= '0;
         r_fm_par  <= '1;
         r_err     <= 1'b0;
         r_err_adr <= '0;
         r_ebus_en <= 1'b0;
         r_ebus_d  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_SCRUB) r_ptr <= r_ptr + 1'b1;
         if (r_state == ST_RUN) begin
            // Write-first: a write presents the incoming word and its true parity.
            if (!con_fm_write_l) begin
               r_fm     <= ar_h;
               r_fm_par <= w_ar_par;
            end else begin
               r_fm     <= r_mem[w_adr];
               r_fm_par <= r_par[w_adr];
            end
         end
         if (w_rd_err) begin
            r_err <= 1'b1;
            if (!r_err || con_fm_err_clr_h) r_err_adr <= w_adr;
         end else if (con_fm_err_clr_h) begin
            r_err     <= 1'b0;
            r_err_adr <= '0;
         end
         r_ebus_en <= diag_read_func_h;
         r_ebus_d  <= diag_read_func_h ? {r_err, w_busy, {EPAD{1'b0}}, r_err_adr, r_fm_par} : '0;
      end
   end

   assign fm_h            = r_fm;
   assign fm_par_h        = r_fm_par;
   assign edp_fm_parity_h = w_ar_par;
   assign fm_parity_err_h = r_err;
   assign fm_err_adr_h    = r_err_adr;
   assign fm_init_busy_h  = w_busy;
   assign ebus_d_e_h      = r_ebus_d;
   assign ebus_en_h       = r_ebus_en;

endmodule

// File: tb/tb_edp_fm_ram.sv
// Directed bench for edp_fm_ram: scrub timing, read/write, write-first, parity status and EBUS diagnostics.
module tb_edp_fm_ram;

   logic        clk = 1'b0;
   logic        rst_l;
   logic [3:0]  adr;
   logic [2:0]  blk;
   logic        wr_l;
   logic [35:0] ar;
   logic        clr;
   logic        diag;
   logic [35:0] fm;
   logic [5:0]  fm_par;
   logic [5:0]  ar_par;
   logic        err;
   logic [6:0]  err_adr;
   logic        busy;
   logic [35:0] ebus_d;
   logic        ebus_en;
`ifdef EDP_FM_PAR_INJECT_EN
   logic [5:0]  inv;
`endif

   int checks = 0;
   int errors = 0;
   int cnt;

   always #5 clk = ~clk;

   edp_fm_ram dut (
      .clk_edp_h        (clk),
      .reset_l          (rst_l),
      .apr_fm_adr_h     (adr),
      .apr_fm_block_h   (blk),
      .con_fm_write_l   (wr_l),
      .ar_h             (ar),
      .con_fm_err_clr_h (clr),
      .diag_read_func_h (diag),
`ifdef EDP_FM_PAR_INJECT_EN
      .diag_fm_par_inv_h(inv),
`endif
      .fm_h             (fm),
      .fm_par_h         (fm_par),
      .edp_fm_parity_h  (ar_par),
      .fm_parity_err_h  (err),
      .fm_err_adr_h     (err_adr),
      .fm_init_busy_h   (busy),
      .ebus_d_e_h       (ebus_d),
      .ebus_en_h        (ebus_en)
   );

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0o expected %0o", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_adr(input logic [6:0] a);
      {blk, adr} = a;
   endtask

   // Counts samples with busy high, starting just after a reset edge.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         tick();
      end
   endtask

   initial begin
      rst_l = 1'b0; wr_l = 1'b1; ar = '0; clr = 1'b0; diag = 1'b0; set_adr(7'o000);
`ifdef EDP_FM_PAR_INJECT_EN
      inv = 6'o00;
`endif
      tick(); tick();
      check("rst_fm", fm, 36'o0);
      check("rst_par", {30'b0, fm_par}, 36'o77);
      check("rst_err", {35'b0, err}, 36'o0);
      check("rst_err_adr", {29'b0, err_adr}, 36'o0);
      check("rst_busy", {35'b0, busy}, 36'o1);
      check("rst_ebus_en", {35'b0, ebus_en}, 36'o0);
      check("rst_ebus_d", ebus_d, 36'o0);

      rst_l = 1'b1;
      count_busy(cnt);
      check("scrub_len", 36'(cnt), 36'd128);

      set_adr(7'o177); tick();
      check("rd177_fm", fm, 36'o0);
      check("rd177_par", {30'b0, fm_par}, 36'o77);
      check("rd177_err", {35'b0, err}, 36'o0);

      // block 3 AC 5
      set_adr(7'o065); ar = 36'o123456701234; wr_l = 1'b0; #1;
      check("ar_par_a", {30'b0, ar_par}, 36'o52);
      tick();
      check("wf_a_fm", fm, 36'o123456701234);
      check("wf_a_par", {30'b0, fm_par}, 36'o52);
      wr_l = 1'b1; ar = '0; set_adr(7'o000); tick();
      check("rd000_fm", fm, 36'o0);
      set_adr(7'o065); tick();
      check("rd065_fm", fm, 36'o123456701234);
      check("rd065_par", {30'b0, fm_par}, 36'o52);
      check("rd065_err", {35'b0, err}, 36'o0);

      set_adr(7'o100); ar = 36'o777777777777; wr_l = 1'b0; #1;
      check("ar_par_ones", {30'b0, ar_par}, 36'o77);
      tick();
      check("wf_ones_fm", fm, 36'o777777777777);
      check("wf_ones_par", {30'b0, fm_par}, 36'o77);

      set_adr(7'o001); ar = 36'o000000000001; #1;
      check("ar_par_one", {30'b0, ar_par}, 36'o76);
      tick();
      wr_l = 1'b1; ar = '0; set_adr(7'o065); tick();
      check("rd065_again", fm, 36'o123456701234);
      set_adr(7'o100); tick();
      check("rd100_fm", fm, 36'o777777777777);
      set_adr(7'o001); tick();
      check("rd001_fm", fm, 36'o1);
      check("rd001_par", {30'b0, fm_par}, 36'o76);
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_noerr", {35'b0, err}, 36'o0);

`ifdef EDP_FM_PAR_INJECT_EN
      set_adr(7'o012); ar = '0; wr_l = 1'b0; inv = 6'o01; #1;
      check("inj_ar_par", {30'b0, ar_par}, 36'o77);
      tick();
      check("inj_wr_noerr", {35'b0, err}, 36'o0);
      set_adr(7'o044); tick();
      wr_l = 1'b1; inv = 6'o00; set_adr(7'o012); tick();
      check("inj_rd_par", {30'b0, fm_par}, 36'o76);
      check("inj_err", {35'b0, err}, 36'o1);
      check("inj_err_adr", {29'b0, err_adr}, 36'o012);
      set_adr(7'o044); tick();
      check("inj2_err", {35'b0, err}, 36'o1);
      check("inj2_err_adr", {29'b0, err_adr}, 36'o012);
      set_adr(7'o065); clr = 1'b1; tick(); clr = 1'b0;
      check("inj_clr_err", {35'b0, err}, 36'o0);
      check("inj_clr_adr", {29'b0, err_adr}, 36'o0);
      set_adr(7'o012); tick();
      check("inj3_err_adr", {29'b0, err_adr}, 36'o012);
      set_adr(7'o044); clr = 1'b1; tick(); clr = 1'b0;
      check("clr_vs_err", {35'b0, err}, 36'o1);
      check("clr_vs_err_adr", {29'b0, err_adr}, 36'o044);
      set_adr(7'o065); clr = 1'b1; tick(); clr = 1'b0;
      check("inj_final_clr", {35'b0, err}, 36'o0);
`endif

      set_adr(7'o065); tick();
      diag = 1'b1; tick();
      check("ebus_en_on", {35'b0, ebus_en}, 36'o1);
      check("ebus_d_run", ebus_d, 36'o52);
      diag = 1'b0; tick();
      check("ebus_en_off", {35'b0, ebus_en}, 36'o0);
      check("ebus_d_off", ebus_d, 36'o0);

      rst_l = 1'b0; tick(); rst_l = 1'b1;
      repeat (60) tick();
      check("mid_scrub_busy", {35'b0, busy}, 36'o1);
      check("mid_scrub_fm", fm, 36'o0);
      rst_l = 1'b0; tick(); rst_l = 1'b1;
      count_busy(cnt);
      check("rescrub_len", 36'(cnt), 36'd128);
      set_adr(7'o065); tick();
      check("scrubbed_fm", fm, 36'o0);
      check("scrubbed_par", {30'b0, fm_par}, 36'o77);
      diag = 1'b1; tick(); diag = 1'b0;
      check("ebus_en_post", {35'b0, ebus_en}, 36'o1);
      check("ebus_busy_bit", {35'b0, ebus_d[34]}, 36'o0);
      check("ebus_d_post", ebus_d, 36'o77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
